fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction fetch controller for the byte-addressed instruction memory.
//  Takes a PC, issues 4 sequential byte reads at PC+0..PC+3 with a req/ack handshake,
//  assembles them into one 32-bit instruction and hands it to decode with a valid/ready handshake.
//  Sits between the PC register and the decode stage; replaces free-running byte counting
//  with a controlled, stallable sequence.
// PARAMETERS
//  N        32  PC / memory address width (bits)
//  TIMEOUT  16  max cycles waiting for i_mem_ack per byte (used only with FETCH_TIMEOUT_EN)
// PORTS
//  i_clk          in   1   clock, all state updates on rising edge
//  i_rst          in   1   reset, synchronous, active-high
//  i_pc           in   N   PC of instruction to fetch
//  i_pc_valid     in   1   i_pc valid
//  o_pc_ready     out  1   sequencer accepts a new PC (high only in IDLE)
//  o_mem_req      out  1   byte read request
//  o_mem_addr     out  N   byte address = pc_latched + o_byte_idx (mod 2^N); 0 when o_mem_req low
//  i_mem_ack      in   1   memory returns i_mem_data for current request this cycle
//  i_mem_data     in   8   read byte
//  o_byte_idx     out  2   index of byte being fetched (0..3)
//  o_instr        out  32  assembled instruction
//  o_instr_valid  out  1   o_instr valid
//  i_instr_ready  in   1   decode accepts o_instr
//  o_fault        out  1   1-cycle pulse: fetch aborted on timeout
// BEHAVIOUR
//  - Reset: state IDLE; o_mem_req, o_mem_addr, o_byte_idx, o_instr, o_instr_valid, o_fault = 0;
//    o_pc_ready = 1 after reset. Reset mid-fetch abandons the fetch; no o_instr_valid is produced.
//  - States: IDLE, FETCH, DONE.
//  - IDLE: o_pc_ready=1. i_pc_valid=1 -> latch i_pc, idx<=0, go FETCH next cycle.
//  - FETCH: o_mem_req=1, o_mem_addr=pc_latched+idx. On i_mem_ack: byte k (k=idx) is written
//    to o_instr[8k+7:8k] (little-endian); idx<3 -> idx+1, stay FETCH (req stays high,
//    address advances next cycle); idx==3 -> go DONE. No ack -> hold req, addr, idx.
//  - DONE: o_instr_valid=1, o_instr stable. i_instr_ready=1 -> go IDLE; o_pc_ready high next cycle.
//  - Min latency: PC accepted at cycle 0, single-cycle acks at cycles 1-4, o_instr_valid at cycle 5.
//  - Address wraps mod 2^N (PC=0xFFFFFFFE -> 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1).
//  - i_pc_valid outside IDLE ignored; i_mem_ack outside FETCH ignored; i_instr_ready
//    outside DONE ignored. o_instr keeps last value while IDLE.
//  - o_pc_ready and o_instr_valid decoded from state register (no comb path from inputs).
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: wait counter cleared on entering FETCH and on each ack; counts
//    cycles in FETCH with no ack; reaching TIMEOUT -> o_fault=1 for one cycle, o_mem_req
//    drops, state IDLE, partial instruction discarded (no o_instr_valid). Ack in the same
//    cycle as the timeout wins (no fault).
//  FETCH_TIMEOUT_EN undefined: no counter; o_fault tied 0; FETCH waits indefinitely for ack.
// TESTING
//  1. PC=0x100, memory acks every cycle with bytes 0x11,0x22,0x33,0x44 -> addrs 0x100..0x103,
//     o_instr=0x44332211, o_instr_valid at cycle 5.
//  2. Ack delayed 3 cycles on byte 2 -> o_mem_addr held at PC+2, o_byte_idx=2 during stall,
//     final o_instr correct.
//  3. PC=0xFFFFFFFE -> addrs 0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001.
//  4. i_instr_ready low 5 cycles in DONE -> o_instr/o_instr_valid stable; new i_pc_valid ignored;
//     ready high -> o_pc_ready=1 next cycle.
//  5. i_rst=1 after byte 1 ack -> next cycle IDLE, all outputs reset, o_pc_ready=1, no valid.
//  6. FETCH_TIMEOUT_EN, TIMEOUT=16, no ack on byte 0 -> o_fault pulse after 16 cycles,
//     IDLE, o_mem_req=0; without macro -> o_mem_req stays high, o_fault=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Byte-wise instruction fetch: reads PC+0..PC+3 over a req/ack port, assembles a little-endian word.
// Optional fetch timeout with fault pulse is enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_pc,
  input  logic         i_pc_valid,
  output logic         o_pc_ready,
  output logic         o_mem_req,
  output logic [N-1:0] o_mem_addr,
  input  logic         i_mem_ack,
  input  logic [7:0]   i_mem_data,
  output logic [1:0]   o_byte_idx,
  output logic [31:0]  o_instr,
  output logic         o_instr_valid,
  input  logic         i_instr_ready,
  output logic         o_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = wait_q;
    fault_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_pc_valid) begin
          pc_d    = i_pc;
          idx_d   = '0;
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      FETCH: begin
        if (i_mem_ack) begin
          instr_d[{idx_q, 3'b000} +: 8] = i_mem_data;
`ifdef FETCH_TIMEOUT_EN
          wait_d = '0;
`endif
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        // Ack takes priority; timeout only fires on a cycle with no ack.
        else if (wait_q == WW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (i_instr_ready) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= wait_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign o_pc_ready    = (state_q == IDLE);
  assign o_mem_req     = (state_q == FETCH);
  assign o_instr_valid = (state_q == DONE);
  assign o_mem_addr    = o_mem_req ? (pc_q + N'(idx_q)) : '0;
  assign o_byte_idx    = idx_q;
  assign o_instr       = instr_q;

`ifdef FETCH_TIMEOUT_EN
  assign o_fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: transaction-level model checked every cycle plus literal checks.
module tb_fetch_sequencer;

  localparam int N       = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic [1:0]  byte_idx;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  logic [31:0] addr_log[$];

  fetch_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_pc_valid(pc_valid), .o_pc_ready(pc_ready),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_data(mem_data),
    .o_byte_idx(byte_idx), .o_instr(instr), .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a fetch is "busy" until retired; m_got counts bytes received so far.
  bit          m_busy = 1'b0;
  int          m_got = 0;
  int          m_stall = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  bit          m_fault = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_got = 0; m_stall = 0; m_pc = '0; m_instr = '0; m_fault = 1'b0;
    end else begin
      m_fault = 1'b0;
      if (!m_busy) begin
        if (pc_valid) begin
          m_busy = 1'b1; m_got = 0; m_stall = 0; m_pc = pc;
        end
      end else if (m_got < 4) begin
        if (mem_ack) begin
          m_instr = (m_instr & ~(32'hFF << (8 * m_got))) | ({24'b0, mem_data} << (8 * m_got));
          m_got++;
          m_stall = 0;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          m_stall++;
          if (m_stall >= TIMEOUT) begin
            m_busy = 1'b0; m_fault = 1'b1; m_got = 0;
          end
`endif
        end
      end else if (instr_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit fetching;
      fetching = m_busy && (m_got < 4);
      check("pc_ready",    32'(pc_ready),    32'(!m_busy));
      check("mem_req",     32'(mem_req),     32'(fetching));
      check("mem_addr",    mem_addr,         fetching ? (m_pc + 32'(m_got)) : 32'h0);
      check("instr_valid", 32'(instr_valid), 32'(m_busy && m_got == 4));
      check("instr",       instr,            m_instr);
      check("fault",       32'(fault),       32'(m_fault));
      if (fetching) check("byte_idx", 32'(byte_idx), 32'(m_got));
      if (mem_req && mem_ack) addr_log.push_back(mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] a);
    int n;
    n = 0;
    while (!pc_ready && n < 50) begin
      tick();
      n++;
    end
    if (!pc_ready) check("pc_ready_wait", 32'(pc_ready), 32'd1);
    addr_log.delete();
    pc = a;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic ack_byte(input logic [7:0] d, input int stall);
    mem_ack = 1'b0;
    repeat (stall) tick();
    mem_ack = 1'b1;
    mem_data = d;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic retire();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    int fault_cnt;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pc_ready", 32'(pc_ready),    32'd1);
    check("rst_req",      32'(mem_req),     32'd0);
    check("rst_addr",     mem_addr,         32'd0);
    check("rst_idx",      32'(byte_idx),    32'd0);
    check("rst_instr",    instr,            32'd0);
    check("rst_valid",    32'(instr_valid), 32'd0);
    check("rst_fault",    32'(fault),       32'd0);

    // 1: back-to-back acks, valid five cycles after PC acceptance
    start_fetch(32'h100);
    ack_byte(8'h11, 0); ack_byte(8'h22, 0); ack_byte(8'h33, 0);
    check("t1_valid_early", 32'(instr_valid), 32'd0);
    ack_byte(8'h44, 0);
    check("t1_valid_c5", 32'(instr_valid), 32'd1);
    check("t1_instr",    instr,            32'h44332211);
    check("t1_naddr",    32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("t1_addr0", addr_log[0], 32'h100);
      check("t1_addr1", addr_log[1], 32'h101);
      check("t1_addr2", addr_log[2], 32'h102);
      check("t1_addr3", addr_log[3], 32'h103);
    end
    retire();
    check("t1_pc_ready", 32'(pc_ready), 32'd1);

    // 2: three-cycle stall on byte 2
    start_fetch(32'h200);
    ack_byte(8'hA1, 0); ack_byte(8'hA2, 0);
    mem_ack = 1'b0;
    tick();
    check("t2_stall_addr", mem_addr,         32'h202);
    check("t2_stall_idx",  32'(byte_idx),    32'd2);
    check("t2_stall_req",  32'(mem_req),     32'd1);
    tick(); tick();
    ack_byte(8'hA3, 0); ack_byte(8'hA4, 0);
    check("t2_instr", instr, 32'hA4A3A2A1);
    retire();

    // 3: address wrap
    start_fetch(32'hFFFF_FFFE);
    ack_byte(8'h01, 0); ack_byte(8'h02, 1); ack_byte(8'h03, 0); ack_byte(8'h04, 0);
    check("t3_naddr", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("t3_addr0", addr_log[0], 32'hFFFF_FFFE);
      check("t3_addr1", addr_log[1], 32'hFFFF_FFFF);
      check("t3_addr2", addr_log[2], 32'h0000_0000);
      check("t3_addr3", addr_log[3], 32'h0000_0001);
    end
    check("t3_instr", instr, 32'h04030201);
    retire();

    // 4: decode backpressure; stray PC and ack ignored while DONE
    start_fetch(32'h300);
    ack_byte(8'h5A, 0); ack_byte(8'h6B, 0); ack_byte(8'h7C, 0); ack_byte(8'h8D, 0);
    pc = 32'h999; pc_valid = 1'b1; mem_ack = 1'b1; mem_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(instr_valid), 32'd1);
      check("t4_hold_instr", instr,            32'h8D7C6B5A);
      check("t4_hold_ready", 32'(pc_ready),    32'd0);
      tick();
    end
    pc_valid = 1'b0; mem_ack = 1'b0;
    retire();
    check("t4_pc_ready", 32'(pc_ready), 32'd1);
    check("t4_idle_instr", instr, 32'h8D7C6B5A);

    // 5: reset after byte 1 acknowledged
    start_fetch(32'h400);
    ack_byte(8'hC0, 0); ack_byte(8'hC1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_pc_ready", 32'(pc_ready),    32'd1);
    check("t5_valid",    32'(instr_valid), 32'd0);
    check("t5_instr",    instr,            32'd0);
    check("t5_req",      32'(mem_req),     32'd0);
    check("t5_addr",     mem_addr,         32'd0);
    check("t5_idx",      32'(byte_idx),    32'd0);
    repeat (3) tick();
    check("t5_no_valid", 32'(instr_valid), 32'd0);

    // 6: no ack on byte 0
    start_fetch(32'h500);
    req_cnt = 0;
    fault_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) req_cnt++;
      if (fault) fault_cnt++;
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    check("t6_req_cycles", 32'(req_cnt),   32'd16);
    check("t6_faults",     32'(fault_cnt), 32'd1);
    check("t6_idle",       32'(pc_ready),  32'd1);
    check("t6_req_low",    32'(mem_req),   32'd0);
    check("t6_no_valid",   32'(instr_valid), 32'd0);
`else
    check("t6_req_cycles", 32'(req_cnt),   32'd20);
    check("t6_faults",     32'(fault_cnt), 32'd0);
    check("t6_req_high",   32'(mem_req),   32'd1);
    check("t6_addr_held",  mem_addr,       32'h500);
    ack_byte(8'hD0, 0); ack_byte(8'hD1, 0); ack_byte(8'hD2, 0); ack_byte(8'hD3, 0);
    check("t6_instr", instr, 32'hD3D2D1D0);
    retire();
`endif
    tick(); tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
